// File: rtl/result_reader_pkg.sv
// Shared definitions for the result readout path: bus widths and FSM encoding.
package result_reader_pkg;

  localparam int ADDR_W         = 8;
  localparam int DATA_W         = 32;
  localparam int BYTES_PER_WORD = 4;
  localparam int IDX_W          = $clog2(BYTES_PER_WORD);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    SEND,
    DONE
  } rd_state_t;

endpackage

// File: rtl/result_reader_word_serializer.sv
// Splits one captured SRAM word into bytes, LSB first, under valid/ready handshake.
module word_serializer
  import result_reader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] data,
  output logic [7:0]        byte_out,
  output logic              byte_valid,
  input  logic              byte_ready,
  output logic              word_done
);

  logic [DATA_W-1:0] shift_reg;
  logic [IDX_W-1:0]  idx;
  logic              valid;
  logic              xfer;
  logic              last;

  assign xfer = valid && byte_ready;
  assign last = (idx == IDX_W'(BYTES_PER_WORD - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      shift_reg <= '0;
      idx       <= '0;
      valid     <= 1'b0;
    end else if (load) begin
      shift_reg <= data;
      idx       <= '0;
      valid     <= 1'b1;
    end else if (xfer) begin
      shift_reg <= shift_reg >> 8;
      idx       <= idx + 1'b1;
      if (last) valid <= 1'b0;
    end
  end

  // Output straight from the register so the byte holds while stalled.
  assign byte_out   = shift_reg[7:0];
  assign byte_valid = valid;
  assign word_done  = xfer && last;

endmodule

// File: rtl/result_reader.sv
// Reads NUM_WORDS words from SRAM starting at BASE_ADDR and streams them out bytewise.
module result_reader
  import result_reader_pkg::*;
#(
  parameter logic [ADDR_W-1:0] BASE_ADDR = 8'd0,
  parameter int                NUM_WORDS = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_start,
  output logic              cs_n,
  output logic              we_n,
  output logic [ADDR_W-1:0] address,
  input  logic              ry,
  input  logic [DATA_W-1:0] read_data,
  output logic [7:0]        byte_out,
  output logic              byte_valid,
  input  logic              byte_ready,
  output logic              rd_busy,
  output logic              rd_done
);

  localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(NUM_WORDS - 1);

  rd_state_t         state, next_state;
  logic [ADDR_W-1:0] word_cnt;
  logic              load;
  logic              word_done;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (rd_start) next_state = REQ;
      REQ:  next_state = WAIT;
      WAIT: if (ry) next_state = SEND;
      SEND: if (word_done) next_state = (word_cnt == LAST_WORD) ? DONE : REQ;
      DONE: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    cs_n    = 1'b1;
    rd_busy = 1'b1;
    rd_done = 1'b0;
    load    = 1'b0;
    case (state)
      IDLE: rd_busy = 1'b0;
      REQ:  cs_n    = 1'b0;
      WAIT: load    = ry;
      DONE: rd_done = 1'b1;
      default: ;
    endcase
  end

  // Address is 8 bits wide, so the increment wraps FF -> 00 naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      word_cnt <= '0;
      address  <= BASE_ADDR;
    end else if (state == IDLE && rd_start) begin
      word_cnt <= '0;
      address  <= BASE_ADDR;
    end else if (state == SEND && word_done && word_cnt != LAST_WORD) begin
      word_cnt <= word_cnt + 1'b1;
      address  <= address + 1'b1;
    end
  end

  assign we_n = 1'b1;

  word_serializer u_ser (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .data       (read_data),
    .byte_out   (byte_out),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .word_done  (word_done)
  );

endmodule

// File: tb/tb_result_reader.sv
// Directed bench for result_reader with BASE_ADDR=FF, NUM_WORDS=2.
module tb_result_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd_start;
  logic        cs_n;
  logic        we_n;
  logic [7:0]  address;
  logic        ry;
  logic [31:0] read_data;
  logic [7:0]  byte_out;
  logic        byte_valid;
  logic        byte_ready;
  logic        rd_busy;
  logic        rd_done;

  int total = 0;
  int bad   = 0;

  logic [7:0] got_bytes[$];
  logic [7:0] got_addrs[$];
  int         done_cnt;

  always #5 clk = ~clk;

  result_reader #(.BASE_ADDR(8'hFF), .NUM_WORDS(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .rd_start   (rd_start),
    .cs_n       (cs_n),
    .we_n       (we_n),
    .address    (address),
    .ry         (ry),
    .read_data  (read_data),
    .byte_out   (byte_out),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .rd_busy    (rd_busy),
    .rd_done    (rd_done)
  );

  always @(negedge clk) begin
    if (!rst) begin
      if (byte_valid && byte_ready) got_bytes.push_back(byte_out);
      if (!cs_n) got_addrs.push_back(address);
      if (rd_done) done_cnt++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    got_bytes.delete();
    got_addrs.delete();
    done_cnt = 0;
  endtask

  task automatic pulse_start();
    rd_start = 1'b1;
    step();
    rd_start = 1'b0;
  endtask

  // Waits for the REQ cycle, holds ry low for dly WAIT cycles, then returns data.
  task automatic serve(input int dly, input logic [31:0] w);
    int n = 0;
    while (cs_n && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("req_seen", {31'd0, cs_n}, 32'd0);
    step();
    for (int i = 0; i < dly; i++) begin
      check("wait_cs_n", {31'd0, cs_n}, 32'd1);
      check("wait_valid", {31'd0, byte_valid}, 32'd0);
      step();
    end
    ry = 1'b1;
    read_data = w;
    step();
    ry = 1'b0;
    read_data = 32'hDEAD_BEEF;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (rd_busy && n < 200) begin
      step();
      n++;
    end
    check("idle_timeout", {31'd0, rd_busy}, 32'd0);
  endtask

  task automatic check_log(input logic [63:0] exp_b, input int exp_done);
    check("nbytes", got_bytes.size(), 8);
    for (int i = 0; i < 8; i++)
      if (i < got_bytes.size()) check("byte", {24'd0, got_bytes[i]}, {24'd0, exp_b[8*i +: 8]});
    check("naddr", got_addrs.size(), 2);
    if (got_addrs.size() == 2) begin
      check("addr0", {24'd0, got_addrs[0]}, 32'h0000_00FF);
      check("addr1", {24'd0, got_addrs[1]}, 32'h0000_0000);
    end
    check("done_cnt", done_cnt, exp_done);
  endtask

  initial begin
    rst = 1'b1; rd_start = 1'b0; ry = 1'b0; read_data = '0; byte_ready = 1'b1;
    done_cnt = 0;
    step(); step();
    rst = 1'b0;
    check("rst_cs_n", {31'd0, cs_n}, 32'd1);
    check("rst_we_n", {31'd0, we_n}, 32'd1);
    check("rst_addr", {24'd0, address}, 32'h0000_00FF);
    check("rst_byte", {24'd0, byte_out}, 32'd0);
    check("rst_valid", {31'd0, byte_valid}, 32'd0);
    check("rst_busy", {31'd0, rd_busy}, 32'd0);
    check("rst_done", {31'd0, rd_done}, 32'd0);

    // Two-word readout, minimum latency, with a stray ry during REQ.
    clear_log();
    pulse_start();
    check("c1_cs_n", {31'd0, cs_n}, 32'd0);
    check("c1_addr", {24'd0, address}, 32'h0000_00FF);
    check("c1_busy", {31'd0, rd_busy}, 32'd1);
    ry = 1'b1; read_data = 32'hCAFE_F00D;
    step();
    check("c2_cs_n", {31'd0, cs_n}, 32'd1);
    check("c2_valid", {31'd0, byte_valid}, 32'd0);
    read_data = 32'h4433_2211;
    step();
    ry = 1'b0; read_data = 32'hDEAD_BEEF;
    check("c3_valid", {31'd0, byte_valid}, 32'd1);
    check("c3_byte", {24'd0, byte_out}, 32'h0000_0011);
    serve(0, 32'h8877_6655);
    wait_idle();
    step();
    check_log(64'h8877_6655_4433_2211, 1);

    // Backpressure on first byte, then a slow SRAM on the second word.
    clear_log();
    byte_ready = 1'b0;
    pulse_start();
    serve(0, 32'hDDCC_BBAA);
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", {31'd0, byte_valid}, 32'd1);
      check("bp_byte", {24'd0, byte_out}, 32'h0000_00AA);
      step();
    end
    byte_ready = 1'b1;
    serve(10, 32'h0F0E_0D0C);
    wait_idle();
    step();
    check_log(64'h0F0E_0D0C_DDCC_BBAA, 1);

    // rd_start while busy must not restart or move the counters.
    clear_log();
    pulse_start();
    serve(0, 32'h1357_9BDF);
    pulse_start();
    check("busy_addr", {24'd0, address}, 32'h0000_00FF);
    serve(3, 32'h2468_ACE0);
    pulse_start();
    wait_idle();
    step();
    check_log(64'h2468_ACE0_1357_9BDF, 1);

    // Reset while the third byte of a word is on the output.
    clear_log();
    pulse_start();
    serve(0, 32'hA1B2_C3D4);
    step();
    step();
    check("pre_rst_byte", {24'd0, byte_out}, 32'h0000_00B2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_rst_valid", {31'd0, byte_valid}, 32'd0);
    check("mid_rst_busy", {31'd0, rd_busy}, 32'd0);
    check("mid_rst_cs_n", {31'd0, cs_n}, 32'd1);
    check("mid_rst_addr", {24'd0, address}, 32'h0000_00FF);

    // Reset beats rd_start in the same cycle.
    rst = 1'b1; rd_start = 1'b1;
    step();
    rst = 1'b0; rd_start = 1'b0;
    check("rst_prio_busy", {31'd0, rd_busy}, 32'd0);
    step();
    check("rst_prio_cs_n", {31'd0, cs_n}, 32'd1);

    // Clean readout after reset recovery.
    clear_log();
    pulse_start();
    serve(1, 32'h0403_0201);
    serve(0, 32'h0807_0605);
    wait_idle();
    step();
    check_log(64'h0807_0605_0403_0201, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
